ext_mem_pipe: RTL

EXT_MEM_PIPE -- requirements
Module: ext_mem_pipe

---
 rtl/ext_mem_pipe.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ext_mem_pipe.sv
// Single-port memory window behind a request/ack bus with fixed read/write latency.
// Optional macro EXT_MEM_BYTE_SEL_EN enables per-byte write lane selection via mem_sel_i.
module ext_mem_pipe #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] MEM_START  = ADDR_WIDTH'(32'h8000_0000),
  parameter int                    MEM_SIZE   = 32'h0200_0000,
  parameter int                    RD_LATENCY = 1,
  parameter int                    WR_LATENCY = 1
) (
  input  logic                    mem_clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mem_sel_i,
  input  logic                    mem_wen_i,
  input  logic                    mem_ren_i,
  output logic                    mem_busy_o,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    mem_ack_o,
  output logic                    mem_err_o
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int SIZE_W = $clog2(MEM_SIZE);
  localparam int IDX_W  = (SIZE_W > OFF_W) ? (SIZE_W - OFF_W) : 1;
  localparam int DEPTH  = MEM_SIZE / BYTES;
  localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);
  localparam logic [3:0] WR_LAT = 4'(WR_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_t                state_r, state_nxt_s;
  logic [2:0]            cnt_r, cnt_nxt_s;
  logic                  err_hold_r, err_nxt_s;
  logic [DATA_WIDTH-1:0] rdata_hold_r, rdata_nxt_s;
  logic                  busy_r, ack_r, err_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic                  accept_s, in_range_s, bad_s, wr_fire_s;
  logic [IDX_W-1:0]      idx_s;
  logic [3:0]            lat_s;
  logic [DATA_WIDTH-1:0] rd_word_s, wmask_s, wmerge_s;

  assign accept_s   = (state_r == ST_IDLE) & (mem_wen_i | mem_ren_i) & ~rst_i;
  assign in_range_s = (mem_addr_i[ADDR_WIDTH-1:SIZE_W] == MEM_START[ADDR_WIDTH-1:SIZE_W]);
  assign bad_s      = ~in_range_s | (mem_wen_i & mem_ren_i);
  assign idx_s      = IDX_W'(mem_addr_i[SIZE_W-1:0] >> OFF_W);
  assign wr_fire_s  = accept_s & mem_wen_i & ~bad_s;
  assign rd_word_s  = mem_r[idx_s];
  assign lat_s      = mem_wen_i ? WR_LAT : RD_LAT;

`ifndef EXT_MEM_BYTE_SEL_EN
  logic sel_unused_s;
  assign sel_unused_s = ^mem_sel_i;
`endif

  // Byte-lane write mask and merged write word
  always_comb begin
    wmask_s = '0;
`ifdef EXT_MEM_BYTE_SEL_EN
    for (int i = 0; i < BYTES; i++) begin
      wmask_s[i*8 +: 8] = {8{mem_sel_i[i]}};
    end
`else
    wmask_s = '1;
`endif
    wmerge_s = (rd_word_s & ~wmask_s) | (mem_wdata_i & wmask_s);
  end

  // Next state, latency counter and completion payload
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (lat_s == 4'd1) begin
            state_nxt_s = ST_ACK;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = 3'(lat_s - 4'd2);
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 3'd0) begin
          state_nxt_s = ST_ACK;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      ST_ACK:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase

    // Writes and errored requests return zero data
    if (accept_s) begin
      err_nxt_s   = bad_s;
      rdata_nxt_s = (bad_s | mem_wen_i) ? '0 : rd_word_s;
    end else begin
      err_nxt_s   = err_hold_r;
      rdata_nxt_s = rdata_hold_r;
    end
  end

  // State register and registered bus outputs
  always_ff @(posedge mem_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 3'd0;
      err_hold_r   <= 1'b0;
      rdata_hold_r <= '0;
      busy_r       <= 1'b0;
      ack_r        <= 1'b0;
      err_r        <= 1'b0;
      rdata_r      <= '0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      err_hold_r   <= err_nxt_s;
      rdata_hold_r <= rdata_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      ack_r        <= (state_nxt_s == ST_ACK);
      err_r        <= (state_nxt_s == ST_ACK) & err_nxt_s;
      rdata_r      <= (state_nxt_s == ST_ACK) ? rdata_nxt_s : '0;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge mem_clk_i) begin
    if (wr_fire_s) begin
      mem_r[idx_s] <= wmerge_s;
    end
  end

  assign mem_busy_o  = busy_r;
  assign mem_ack_o   = ack_r;
  assign mem_err_o   = err_r;
  assign mem_rdata_o = rdata_r;

endmodule
